// File: rtl/lbist_pkg.sv
// Shared definitions for the logic-BIST session controller.
// Latency: n/a (types, encodings and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   ENC_*          3-bit state encodings (IDLE=0 .. DONE=6)
//   lbist_state_e  controller state type built from those encodings
//   lbist_out_t    registered control outputs, grouped for one-shot update
//   session_len()  cycles from the cycle after start up to done=1
//                  (pause cycles excluded)
package lbist_pkg;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_INIT    = 3'd1;
    localparam logic [2:0] ENC_SHIFT   = 3'd2;
    localparam logic [2:0] ENC_CAPTURE = 3'd3;
    localparam logic [2:0] ENC_UNLOAD  = 3'd4;
    localparam logic [2:0] ENC_COMPARE = 3'd5;
    localparam logic [2:0] ENC_DONE    = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ENC_IDLE,
        INIT    = ENC_INIT,
        SHIFT   = ENC_SHIFT,
        CAPTURE = ENC_CAPTURE,
        UNLOAD  = ENC_UNLOAD,
        COMPARE = ENC_COMPARE,
        DONE    = ENC_DONE
    } lbist_state_e;

    typedef struct packed {
        logic tpg_init;
        logic misr_init;
        logic tpg_en;
        logic scan_en;
        logic misr_en;
        logic busy;
        logic done;
    } lbist_out_t;

    // INIT + one (shift + capture) round per pattern + unload + compare.
    function automatic int session_len(input int n_patterns, input int chain_len);
        return 1 + n_patterns * (chain_len + 1) + chain_len + 1;
    endfunction

endpackage

// File: rtl/lbist_ctrl_if.sv
// Control/status bundle between the BIST sequencer and the TPG/scan/MISR path.
// Latency: n/a (wires only).
// Backpressure: none; start is a plain request, the controller ignores it while busy.
//
// Signals:
//   start      request to begin a session (host -> controller)
//   misr_sig   current MISR signature (datapath -> controller)
//   tpg_init   reload TPG seed pulse
//   misr_init  clear MISR pulse
//   tpg_en     advance TPG
//   scan_en    1 = shift, 0 = functional capture
//   misr_en    MISR compacts chain outputs
//   busy/done/pass  session status
// Modports: master = controller side, slave = host/datapath side.
interface lbist_ctrl_if #(
    parameter int SIG_W = 24
);
    logic             start;
    logic [SIG_W-1:0] misr_sig;
    logic             tpg_init;
    logic             misr_init;
    logic             tpg_en;
    logic             scan_en;
    logic             misr_en;
    logic             busy;
    logic             done;
    logic             pass;

    modport master (
        input  start,
        input  misr_sig,
        output tpg_init,
        output misr_init,
        output tpg_en,
        output scan_en,
        output misr_en,
        output busy,
        output done,
        output pass
    );

    modport slave (
        output start,
        output misr_sig,
        input  tpg_init,
        input  misr_init,
        input  tpg_en,
        input  scan_en,
        input  misr_en,
        input  busy,
        input  done,
        input  pass
    );

endinterface

// File: rtl/lbist_cnt.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
// Latency: count visible one cycle after en; tc is combinational from the count.
// Backpressure: none; en simply stalls the count.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (count -> 0)
//   clr        synchronous clear, wins over en
//   en         increment by one
//   cnt        current count
//   tc         cnt == LAST
// The counter never wraps on its own; the owner clears it at tc when it
// wants a modulo count, so a count of LAST+1 is representable if W allows.
module lbist_cnt #(
    parameter int W    = 4,
    parameter int LAST = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(LAST));

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST session sequencer: init TPG/MISR, N shift/capture rounds, unload, signature compare.
// Latency: done rises session_len(N_PATTERNS, CHAIN_LEN) cycles after the cycle start is sampled.
// Backpressure: start ignored while busy; optional pause freezes shift/unload in place.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset -> IDLE, counters 0, outputs 0
//   pause (only with `define LBIST_PAUSE_EN) stall SHIFT/UNLOAD, ignored elsewhere
//   bus   lbist_ctrl_if.master: start/misr_sig in, TPG/scan/MISR controls and status out
//
// Optional feature macro: LBIST_PAUSE_EN. Without it there is no pause port.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int               N_PATTERNS = 1000,
    parameter int               CHAIN_LEN  = 64,
    parameter int               SIG_W      = 24,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic         clk,
    input  logic         rst,
`ifdef LBIST_PAUSE_EN
    input  logic         pause,
`endif
    lbist_ctrl_if.master bus
);

    localparam int SW = $clog2(CHAIN_LEN);
    localparam int PW = $clog2(N_PATTERNS + 1);

    lbist_state_e  state;
    lbist_state_e  state_nxt;
    lbist_out_t    out_q;
    lbist_out_t    out_nxt;
    logic          pass_q;
    logic          pass_nxt;

    logic [SW-1:0] shift_cnt;
    logic          shift_tc;
    logic          shift_clr;
    logic [PW-1:0] pat_cnt;
    logic          pat_tc;
    logic          pat_clr;
    logic          pat_en;

    logic          shift_phase;
    logic          hold;
    logic          adv;
    logic          first_pat_nxt;

    // SHIFT and UNLOAD both walk the chain with the shift counter.
    assign shift_phase = (state == SHIFT) || (state == UNLOAD);

`ifdef LBIST_PAUSE_EN
    assign hold = pause && shift_phase;
`else
    assign hold = 1'b0;
`endif

    // One chain-shift step actually taken this cycle.
    assign adv = shift_phase && !hold;

    // Cleared at session start and at the end of every chain walk, so the
    // next SHIFT/UNLOAD always starts from 0.
    assign shift_clr = (state == INIT) || (adv && shift_tc);
    assign pat_clr   = (state == INIT);
    assign pat_en    = (state == CAPTURE);

    lbist_cnt #(
        .W    (SW),
        .LAST (CHAIN_LEN - 1)
    ) u_shift_cnt (
        .clk (clk),
        .rst (rst),
        .clr (shift_clr),
        .en  (adv),
        .cnt (shift_cnt),
        .tc  (shift_tc)
    );

    // tc marks the capture of the final pattern (count before increment).
    lbist_cnt #(
        .W    (PW),
        .LAST (N_PATTERNS - 1)
    ) u_pat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pat_clr),
        .en  (pat_en),
        .cnt (pat_cnt),
        .tc  (pat_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = INIT;
            INIT:    state_nxt = SHIFT;
            SHIFT:   if (adv && shift_tc) state_nxt = CAPTURE;
            CAPTURE: state_nxt = pat_tc ? UNLOAD : SHIFT;
            UNLOAD:  if (adv && shift_tc) state_nxt = COMPARE;
            COMPARE: state_nxt = DONE;
            DONE:    if (bus.start) state_nxt = INIT;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being
    // entered. The first pattern's shift has nothing valid in the chains
    // yet; that is the SHIFT entered from INIT or held with pat_cnt still 0
    // (CAPTURE always leads into pattern >= 1).
    assign first_pat_nxt = (state == INIT) || ((state == SHIFT) && (pat_cnt == '0));

    always_comb begin
        out_nxt = '0;
        case (state_nxt)
            INIT: begin
                out_nxt.tpg_init  = 1'b1;
                out_nxt.misr_init = 1'b1;
                out_nxt.busy      = 1'b1;
            end
            SHIFT: begin
                out_nxt.tpg_en  = 1'b1;
                out_nxt.scan_en = 1'b1;
                out_nxt.misr_en = !first_pat_nxt;
                out_nxt.busy    = 1'b1;
            end
            CAPTURE: begin
                out_nxt.busy = 1'b1;
            end
            UNLOAD: begin
                out_nxt.scan_en = 1'b1;
                out_nxt.misr_en = 1'b1;
                out_nxt.busy    = 1'b1;
            end
            COMPARE: begin
                out_nxt.busy = 1'b1;
            end
            DONE: begin
                out_nxt.done = 1'b1;
            end
            default: out_nxt = '0;
        endcase
    end

    // misr_sig is judged during COMPARE, i.e. after the final unload edge.
    always_comb begin
        pass_nxt = pass_q;
        if (state == COMPARE) begin
            pass_nxt = (bus.misr_sig == GOLDEN_SIG);
        end else if (state_nxt == INIT) begin
            pass_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            out_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            out_q  <= out_nxt;
            pass_q <= pass_nxt;
        end
    end

    // A paused cycle must not move TPG, scan chains or MISR, so the shift
    // controls are gated in the same cycle the pause is seen.
    assign bus.tpg_init  = out_q.tpg_init;
    assign bus.misr_init = out_q.misr_init;
    assign bus.tpg_en    = out_q.tpg_en  && !hold;
    assign bus.scan_en   = out_q.scan_en && !hold;
    assign bus.misr_en   = out_q.misr_en && !hold;
    assign bus.busy      = out_q.busy;
    assign bus.done      = out_q.done;
    assign bus.pass      = pass_q;

    a_init_excl_adv: assert property (@(posedge clk) disable iff (rst)
        !(bus.tpg_init && bus.tpg_en));

    a_shift_restart: assert property (@(posedge clk) disable iff (rst)
        (adv && shift_tc) |=> (shift_cnt == '0));

endmodule

// File: tb/tb_lbist_ctrl.sv
// Randomised session bench for lbist_ctrl against a cycle-timeline reference model.
// Latency: checks every cycle of each session plus aggregate counts and done latency.
// Backpressure: start noise during sessions, optional pause stalls (LBIST_PAUSE_EN), mid-session resets.
module tb_lbist_ctrl;

    localparam int               N_PAT  = 3;
    localparam int               CHAIN  = 4;
    localparam int               SIG_W  = 24;
    localparam logic [SIG_W-1:0] GOLDEN = 24'h5A3C96;
`ifdef LBIST_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    // One expected cycle. v = {tpg_init, misr_init, tpg_en, scan_en, misr_en, busy, done, pass}.
    typedef struct {
        logic [7:0] v;
        bit         ps;      // pause value driven this cycle
        bit         held;    // pause actually stalls this cycle
        bit         is_cap;
        bit         is_cmp;
    } cyc_t;

    logic clk;
    logic rst;
`ifdef LBIST_PAUSE_EN
    logic pause;
`endif

    lbist_ctrl_if #(.SIG_W(SIG_W)) bus_if ();

    lbist_ctrl #(
        .N_PATTERNS (N_PAT),
        .CHAIN_LEN  (CHAIN),
        .SIG_W      (SIG_W),
        .GOLDEN_SIG (GOLDEN)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef LBIST_PAUSE_EN
        .pause (pause),
`endif
        .bus   (bus_if)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    cyc_t       tl[$];
    int         npause;
    logic [7:0] prev_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mkv(input bit ti, input bit mi, input bit te, input bit se,
                                       input bit me, input bit b, input bit d, input bit p);
        return {ti, mi, te, se, me, b, d, p};
    endfunction

    function automatic logic [SIG_W-1:0] rnd_sig();
        return SIG_W'($urandom);
    endfunction

    // Inputs change 1ns after the edge and hold for the whole cycle;
    // outputs of that cycle are read 1ns later.
    task automatic step(input bit st, input bit ps, input bit rs,
                        input logic [SIG_W-1:0] sig, output logic [7:0] obs);
        @(posedge clk);
        #1;
        bus_if.start    = st;
        rst             = rs;
        bus_if.misr_sig = sig;
`ifdef LBIST_PAUSE_EN
        pause = ps;
`else
        if (ps) bus_if.misr_sig = sig;
`endif
        #1;
        obs = {bus_if.tpg_init, bus_if.misr_init, bus_if.tpg_en, bus_if.scan_en,
               bus_if.misr_en, bus_if.busy, bus_if.done, bus_if.pass};
    endtask

    task automatic add(input logic [7:0] v, input bit ps, input bit held,
                       input bit is_cap, input bit is_cmp);
        cyc_t c;
        c.v = v; c.ps = ps; c.held = held; c.is_cap = is_cap; c.is_cmp = is_cmp;
        tl.push_back(c);
    endtask

    // pause asserted in a state where it must have no effect
    function automatic bit noise_pause();
        return HAS_PAUSE && ($urandom_range(0, 3) == 0);
    endfunction

    task automatic maybe_pause(input int pct, input int force_n);
        int n;
        n = force_n;
        if (n == 0 && pct > 0 && $urandom_range(0, 99) < pct) n = $urandom_range(1, 3);
        if (!HAS_PAUSE) n = 0;
        for (int i = 0; i < n; i++) add(mkv(0,0,0,0,0,1,0,0), 1'b1, 1'b1, 1'b0, 1'b0);
        npause += n;
    endtask

    // Expected session timeline, cycle by cycle, starting at the INIT cycle.
    task automatic build_timeline(input int pause_pct, input bit fixed_pause);
        tl.delete();
        npause = 0;
        add(mkv(1,1,0,0,0,1,0,0), noise_pause(), 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < N_PAT; p++) begin
            for (int s = 0; s < CHAIN; s++) begin
                maybe_pause(pause_pct, 0);
                add(mkv(0,0,1,1,(p > 0),1,0,0), 1'b0, 1'b0, 1'b0, 1'b0);
            end
            add(mkv(0,0,0,0,0,1,0,0), noise_pause(), 1'b0, 1'b1, 1'b0);
        end
        for (int s = 0; s < CHAIN; s++) begin
            maybe_pause(pause_pct, (fixed_pause && s == 2) ? 5 : 0);
            add(mkv(0,0,0,1,1,1,0,0), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        add(mkv(0,0,0,0,0,1,0,0), noise_pause(), 1'b0, 1'b0, 1'b1);
    endtask

    // start_mode: 0 start low during session, 1 random, 2 held high.
    // rst_at: -1 none, -2 second CAPTURE, -3 random cycle, else timeline index.
    task automatic run_session(input bit match, input int flip_bit, input int start_mode,
                               input int pause_pct, input bit fixed_pause, input int rst_at);
        logic [7:0]       obs;
        logic [SIG_W-1:0] sig;
        logic [SIG_W-1:0] mask;
        int               r;
        int               ncap;
        int               first_done;
        int               n_ti, n_mi, n_te, n_me, n_cap;
        int               nd;
        bit               st;
        logic [7:0]       done_v;

        build_timeline(pause_pct, fixed_pause);
        r = rst_at;
        if (r == -2) begin
            ncap = 0;
            r = -1;
            for (int i = 0; i < tl.size(); i++) begin
                if (tl[i].is_cap) begin
                    ncap++;
                    if (ncap == 2) r = i;
                end
            end
        end else if (r == -3) begin
            r = $urandom_range(0, tl.size() - 1);
        end
        mask = '0;
        mask[flip_bit] = 1'b1;

        step(1'b1, noise_pause(), 1'b0, rnd_sig(), obs);
        chk("pre_start", obs, prev_v);

        first_done = -1;
        n_ti = 0; n_mi = 0; n_te = 0; n_me = 0; n_cap = 0;
        for (int k = 0; k < tl.size(); k++) begin
            case (start_mode)
                2:       st = 1'b1;
                1:       st = 1'($urandom_range(0, 1));
                default: st = 1'b0;
            endcase
            sig = rnd_sig();
            if (tl[k].is_cmp) sig = match ? GOLDEN : (GOLDEN ^ mask);
            step(st, tl[k].ps, (k == r), sig, obs);
            chk($sformatf("cyc%0d", k), obs, tl[k].v);
            if (obs[1] && first_done < 0) first_done = k;
            if (!tl[k].held) begin
                n_ti += int'(obs[7]);
                n_mi += int'(obs[6]);
                n_te += int'(obs[5]);
                n_me += int'(obs[3]);
                if (obs[2] && !obs[4] && !obs[7] && !tl[k].is_cmp) n_cap++;
            end
            if (k == r) begin
                step(1'b0, 1'b0, 1'b0, rnd_sig(), obs);
                chk("post_rst", obs, 8'h00);
                prev_v = 8'h00;
                return;
            end
        end

        done_v = mkv(0,0,0,0,0,0,1,match);
        nd = $urandom_range(1, 3);
        for (int d = 0; d < nd; d++) begin
            step(1'b0, noise_pause(), 1'b0, rnd_sig(), obs);
            chk($sformatf("done%0d", d), obs, done_v);
            if (obs[1] && first_done < 0) first_done = tl.size() + d;
        end
        prev_v = done_v;

        chk("n_tpg_init", n_ti, 1);
        chk("n_misr_init", n_mi, 1);
        chk("n_tpg_en", n_te, N_PAT * CHAIN);
        chk("n_misr_en", n_me, (N_PAT - 1) * CHAIN + CHAIN);
        chk("n_capture", n_cap, N_PAT);
        chk("done_latency", first_done, 1 + N_PAT * (CHAIN + 1) + CHAIN + 1 + npause);
    endtask

    initial begin
        logic [7:0] obs;
        rst             = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.misr_sig = '0;
`ifdef LBIST_PAUSE_EN
        pause = 1'b0;
`endif
        step(1'b0, 1'b0, 1'b1, '0, obs);
        step(1'b0, 1'b0, 1'b1, '0, obs);
        step(1'b0, 1'b0, 1'b0, '0, obs);
        chk("reset_outs", obs, 8'h00);
        step(1'b0, 1'b0, 1'b0, rnd_sig(), obs);
        chk("idle_outs", obs, 8'h00);
        prev_v = 8'h00;

        // nominal session, matching signature
        run_session(1'b1, 0, 0, 0, 1'b0, -1);
        // restart from DONE with start held high, signature GOLDEN^1
        run_session(1'b0, 0, 2, 0, 1'b0, -1);
        // reset in the second capture, then a full session from IDLE
        run_session(1'b1, 0, 0, 0, 1'b0, -2);
        run_session(1'b1, 0, 0, 0, 1'b0, -1);
`ifdef LBIST_PAUSE_EN
        // 5-cycle pause in the middle of UNLOAD
        run_session(1'b1, 0, 0, 0, 1'b1, -1);
`endif
        for (int i = 0; i < 10; i++) begin
            run_session(1'($urandom_range(0, 1)), $urandom_range(0, SIG_W - 1),
                        $urandom_range(0, 2), 20, 1'b0,
                        ($urandom_range(0, 3) == 0) ? -3 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
